fir_coef_bank_mgr: RTL and testbench

//  Double-buffered, multi-filter FIR coefficient store. The host loads 16-bit coefficients byte-wise

---
 rtl/fir_coef_pkg.sv | 25 ++
 rtl/coef_dp_ram.sv | 33 +++
 rtl/fir_coef_bank_mgr.sv | 182 ++++++++++++++++++
 tb/tb_fir_coef_bank_mgr.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coef_pkg.sv
// Shared types and helpers for the FIR coefficient bank manager.
package fir_coef_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_LOAD        = 2'd1,
    ST_COMPLETE    = 2'd2,
    ST_COMMIT_PEND = 2'd3
  } coef_ld_state_e;

  // Bit positions inside err_flags = {wr_while_busy, partial_commit, bad_taps}
  localparam int ERR_BAD_TAPS       = 0;
  localparam int ERR_PARTIAL_COMMIT = 1;
  localparam int ERR_WR_WHILE_BUSY  = 2;
  localparam int ERR_W              = 3;

  function automatic int calc_fsel_w(input int num_filters);
    return (num_filters > 1) ? $clog2(num_filters) : 1;
  endfunction

  function automatic int calc_tap_w(input int max_taps);
    return $clog2(max_taps);
  endfunction

endpackage

// File: rtl/coef_dp_ram.sv
// Simple dual-port coefficient RAM: one write port, one registered read port.
module coef_dp_ram #(
  parameter int DW    = 16,
  parameter int AW    = 11,
  parameter int DEPTH = 2048
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // Array write; no reset so the storage maps onto block RAM
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; output holds its value when no read is requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fir_coef_bank_mgr.sv
// Double-buffered multi-filter FIR coefficient store with byte-wise host load
// and sample-aligned shadow/active bank swap.
module fir_coef_bank_mgr
  import fir_coef_pkg::*;
#(
  parameter  int NUM_FILTERS = 4,
  parameter  int MAX_TAPS    = 256,
  parameter  int COEF_W      = 16,
  localparam int FSEL_W      = calc_fsel_w(NUM_FILTERS),
  localparam int TAP_W       = calc_tap_w(MAX_TAPS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   coef_rst,
  input  logic [FSEL_W-1:0]      filt_sel,
  input  logic [TAP_W:0]         taps_per_filter,
  input  logic                   lsb_wr,
  input  logic                   msb_wr,
  input  logic [7:0]             coef_lsb_data,
  input  logic [7:0]             coef_msb_data,
  input  logic                   commit_req,
  input  logic                   sample_strobe,
  input  logic                   rd_en,
  input  logic [FSEL_W-1:0]      rd_filt,
  input  logic [TAP_W-1:0]       rd_addr,
  output logic [COEF_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic                   wr_addr_zero,
  output logic                   load_done,
  output logic                   busy,
  output logic [ERR_W-1:0]       err_flags,
  output logic [NUM_FILTERS-1:0] active_bank
);

  localparam int AW    = FSEL_W + 1 + TAP_W;
  localparam int DEPTH = NUM_FILTERS * 2 * MAX_TAPS;
  localparam logic [TAP_W:0] MAX_TAPS_V = (TAP_W+1)'(MAX_TAPS);

  coef_ld_state_e r_state, w_state_nxt;

  logic [TAP_W-1:0]       r_wr_ptr;
  logic [7:0]             r_lsb_hold;
  logic [FSEL_W-1:0]      r_filt_l;
  logic [TAP_W:0]         r_taps_l;
  logic [NUM_FILTERS-1:0] r_active_bank;
  logic                   r_load_done;
  logic                   r_rd_valid;
  logic [ERR_W-1:0]       r_err;

  logic                   w_first;
  logic                   w_wr_en;
  logic                   w_last;
  logic                   w_swap;
  logic [ERR_W-1:0]       w_err_set;
  logic                   w_bad_taps;
  logic [TAP_W:0]         w_taps_new;
  logic [TAP_W:0]         w_taps_cur;
  logic [FSEL_W-1:0]      w_wr_filt;
  logic [AW-1:0]          w_waddr;
  logic [AW-1:0]          w_raddr;
  logic [COEF_W-1:0]      w_wdata;

  assign w_bad_taps = (taps_per_filter == '0) || (taps_per_filter > MAX_TAPS_V);
  assign w_taps_new = w_bad_taps ? MAX_TAPS_V : taps_per_filter;

  // Next-state and write/commit control; coef_rst drops every same-cycle request
  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_wr_en     = 1'b0;
    w_last      = 1'b0;
    w_swap      = 1'b0;
    w_err_set   = '0;
    w_taps_cur  = r_taps_l;
    if (!coef_rst) begin
      unique case (r_state)
        ST_IDLE, ST_COMPLETE: begin
          if (msb_wr) begin
            w_first     = 1'b1;
            w_wr_en     = 1'b1;
            w_state_nxt = ST_LOAD;
            if (w_bad_taps) w_err_set[ERR_BAD_TAPS] = 1'b1;
            // A new load starting alongside a commit would swap a half-written
            // set, so the write wins and the commit is flagged as partial.
            if (commit_req && (r_state == ST_COMPLETE))
              w_err_set[ERR_PARTIAL_COMMIT] = 1'b1;
          end else if (commit_req && (r_state == ST_COMPLETE)) begin
            w_state_nxt = ST_COMMIT_PEND;
          end
        end
        ST_LOAD: begin
          if (msb_wr)     w_wr_en = 1'b1;
          if (commit_req) w_err_set[ERR_PARTIAL_COMMIT] = 1'b1;
        end
        ST_COMMIT_PEND: begin
          if (msb_wr) w_err_set[ERR_WR_WHILE_BUSY] = 1'b1;
          if (sample_strobe) begin
            w_swap      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      if (w_first) w_taps_cur = w_taps_new;
      w_last = w_wr_en && ({1'b0, r_wr_ptr} == (w_taps_cur - (TAP_W+1)'(1)));
      if (w_last) w_state_nxt = ST_COMPLETE;
    end
  end

  // Load FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Write pointer, byte holding register, latched load target and sticky errors
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_lsb_hold  <= '0;
      r_filt_l    <= '0;
      r_taps_l    <= '0;
      r_err       <= '0;
      r_load_done <= 1'b0;
    end else begin
      r_load_done <= w_last;
      if (coef_rst) begin
        r_wr_ptr   <= '0;
        r_lsb_hold <= '0;
        r_err      <= '0;
      end else begin
        if (lsb_wr) r_lsb_hold <= coef_lsb_data;
        if (w_first) begin
          r_filt_l <= filt_sel;
          r_taps_l <= w_taps_new;
        end
        if (w_wr_en) r_wr_ptr <= w_last ? '0 : r_wr_ptr + 1'b1;
        r_err <= r_err | w_err_set;
      end
    end
  end

  // Per-filter active bank select, toggled only at a sample boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_active_bank <= '0;
    else if (w_swap) r_active_bank[r_filt_l] <= ~r_active_bank[r_filt_l];
  end

  // Read valid tracks the read request with one cycle of latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rd_valid <= 1'b0;
    else          r_rd_valid <= rd_en;
  end

  assign w_wr_filt = w_first ? filt_sel : r_filt_l;
  assign w_waddr   = {w_wr_filt, ~r_active_bank[w_wr_filt], r_wr_ptr};
  assign w_wdata   = {coef_msb_data, (lsb_wr ? coef_lsb_data : r_lsb_hold)};
  assign w_raddr   = {rd_filt, r_active_bank[rd_filt], rd_addr};

  coef_dp_ram #(
    .DW    (COEF_W),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_we    (w_wr_en),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (rd_en),
    .i_raddr (w_raddr),
    .o_rdata (rd_data)
  );

  assign rd_valid     = r_rd_valid;
  assign wr_addr_zero = (r_wr_ptr == '0);
  assign load_done    = r_load_done;
  assign busy         = (r_state == ST_COMMIT_PEND);
  assign err_flags    = r_err;
  assign active_bank  = r_active_bank;

endmodule

// File: tb/tb_fir_coef_bank_mgr.sv
// Bench for fir_coef_bank_mgr: read data checked through an expected-value queue.
module tb_fir_coef_bank_mgr;

  logic        clk = 1'b0;
  logic        reset_n, coef_rst;
  logic [1:0]  filt_sel;
  logic [8:0]  taps_per_filter;
  logic        lsb_wr, msb_wr;
  logic [7:0]  coef_lsb_data, coef_msb_data;
  logic        commit_req, sample_strobe, rd_en;
  logic [1:0]  rd_filt;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid, wr_addr_zero, load_done, busy;
  logic [2:0]  err_flags;
  logic [3:0]  active_bank;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_mem [4][2][256];
  logic [3:0]  m_bank;
  logic [15:0] sb_q [$];

  always #5 clk = ~clk;

  fir_coef_bank_mgr #(
    .NUM_FILTERS (4),
    .MAX_TAPS    (256),
    .COEF_W      (16)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .coef_rst        (coef_rst),
    .filt_sel        (filt_sel),
    .taps_per_filter (taps_per_filter),
    .lsb_wr          (lsb_wr),
    .msb_wr          (msb_wr),
    .coef_lsb_data   (coef_lsb_data),
    .coef_msb_data   (coef_msb_data),
    .commit_req      (commit_req),
    .sample_strobe   (sample_strobe),
    .rd_en           (rd_en),
    .rd_filt         (rd_filt),
    .rd_addr         (rd_addr),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .wr_addr_zero    (wr_addr_zero),
    .load_done       (load_done),
    .busy            (busy),
    .err_flags       (err_flags),
    .active_bank     (active_bank)
  );

  // Read scoreboard: every valid read result is matched against the queue head
  always begin
    @(posedge clk);
    #2;
    if (rd_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: rd_valid=1 rd_data=%h with no read outstanding", rd_data);
      end else begin
        logic [15:0] exp_v;
        exp_v = sb_q.pop_front();
        if (rd_data !== exp_v) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", rd_data, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_tap(input int f, input int taps, input int idx,
                        input logic [15:0] v, input bit sep, input bit exp_done);
    int sb;
    if (sep) begin
      lsb_wr = 1'b1; coef_lsb_data = v[7:0];
      tick();
      lsb_wr = 1'b0; coef_lsb_data = 8'hEE;
    end else begin
      lsb_wr = 1'b1; coef_lsb_data = v[7:0];
    end
    msb_wr = 1'b1; coef_msb_data = v[15:8];
    filt_sel = f[1:0]; taps_per_filter = taps[8:0];
    sb = m_bank[f] ? 0 : 1;
    m_mem[f][sb][idx] = v;
    tick();
    msb_wr = 1'b0; lsb_wr = 1'b0;
    checks++;
    if (load_done !== exp_done) begin
      errors++;
      $display("FAIL load_done f%0d idx%0d: got %b expected %b", f, idx, load_done, exp_done);
    end
  endtask

  task automatic do_read(input int f, input int a);
    rd_en = 1'b1; rd_filt = f[1:0]; rd_addr = a[7:0];
    sb_q.push_back(m_mem[f][m_bank[f]][a]);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic do_commit(input bit exp_busy);
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL commit_busy: got %b expected %b", busy, exp_busy);
    end
  endtask

  task automatic do_strobe(input int f);
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    m_bank[f] = ~m_bank[f];
    checks++;
    if (busy !== 1'b0 || active_bank !== m_bank) begin
      errors++;
      $display("FAIL swap f%0d: busy=%b bank=%b expected busy=0 bank=%b", f, busy, active_bank, m_bank);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; coef_rst = 1'b0; filt_sel = '0; taps_per_filter = '0;
    lsb_wr = 1'b0; msb_wr = 1'b0; coef_lsb_data = '0; coef_msb_data = '0;
    commit_req = 1'b0; sample_strobe = 1'b0; rd_en = 1'b0; rd_filt = '0; rd_addr = '0;
    m_bank = '0;
    tick(); tick();
    checks++;
    if (rd_data !== 16'h0 || rd_valid !== 1'b0 || load_done !== 1'b0 || busy !== 1'b0 ||
        err_flags !== 3'b000 || active_bank !== 4'b0000 || wr_addr_zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: rd_data=%h rd_valid=%b load_done=%b busy=%b err=%b bank=%b wz=%b expected 0000 0 0 0 000 0000 1",
               rd_data, rd_valid, load_done, busy, err_flags, active_bank, wr_addr_zero);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || wr_addr_zero !== 1'b1 || active_bank !== 4'b0000) begin
      errors++;
      $display("FAIL post_reset: busy=%b wz=%b bank=%b expected 0 1 0000", busy, wr_addr_zero, active_bank);
    end
  endtask

  task automatic test_load_commit();
    for (int unsigned k = 0; k < 4; k++)
      wr_tap(2, 4, int'(k), 16'h0101 * 16'(k + 1), (k % 2) == 0, k == 3);
    checks++;
    if (wr_addr_zero !== 1'b1) begin
      errors++;
      $display("FAIL ptr_wrap: wr_addr_zero got %b expected 1", wr_addr_zero);
    end
    do_commit(1'b1);
    do_strobe(2);
    for (int unsigned a = 0; a < 4; a++) do_read(2, int'(a));
  endtask

  task automatic test_shadow_isolation();
    wr_tap(1, 2, 0, 16'hAAAA, 1'b0, 1'b0);
    wr_tap(1, 2, 1, 16'hAAAA, 1'b0, 1'b1);
    do_commit(1'b1);
    do_strobe(1);
    wr_tap(1, 2, 0, 16'h5555, 1'b0, 1'b0);
    wr_tap(1, 2, 1, 16'h5555, 1'b0, 1'b1);
    do_read(1, 0);
    do_read(1, 1);
    do_commit(1'b1);
    // read in the swap cycle must still see the old bank
    sample_strobe = 1'b1;
    rd_en = 1'b1; rd_filt = 2'd1; rd_addr = 8'd0;
    sb_q.push_back(m_mem[1][m_bank[1]][0]);
    tick();
    sample_strobe = 1'b0; rd_en = 1'b0;
    m_bank[1] = ~m_bank[1];
    do_read(1, 0);
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h5555) begin
      errors++;
      $display("FAIL rd_hold: rd_valid=%b rd_data=%h expected 0 5555", rd_valid, rd_data);
    end
  endtask

  task automatic test_commit_strobe_same_cycle();
    wr_tap(0, 1, 0, 16'h1234, 1'b1, 1'b1);
    commit_req = 1'b1; sample_strobe = 1'b1;
    tick();
    commit_req = 1'b0; sample_strobe = 1'b0;
    checks++;
    if (busy !== 1'b1 || active_bank !== m_bank) begin
      errors++;
      $display("FAIL same_cycle_strobe: busy=%b bank=%b expected 1 %b", busy, active_bank, m_bank);
    end
    do_strobe(0);
    do_read(0, 0);
  endtask

  task automatic test_errors();
    wr_tap(3, 4, 0, 16'h3001, 1'b0, 1'b0);
    wr_tap(3, 4, 1, 16'h3002, 1'b0, 1'b0);
    do_commit(1'b0);
    checks++;
    if (err_flags !== 3'b010 || active_bank !== m_bank) begin
      errors++;
      $display("FAIL partial_commit: err=%b bank=%b expected 010 %b", err_flags, active_bank, m_bank);
    end
    wr_tap(3, 4, 2, 16'h3003, 1'b0, 1'b0);
    wr_tap(3, 4, 3, 16'h3004, 1'b0, 1'b1);
    do_commit(1'b1);
    msb_wr = 1'b1; lsb_wr = 1'b1; coef_msb_data = 8'hDE; coef_lsb_data = 8'hAD;
    filt_sel = 2'd3; taps_per_filter = 9'd4;
    tick();
    msb_wr = 1'b0; lsb_wr = 1'b0;
    checks++;
    if (err_flags !== 3'b110 || wr_addr_zero !== 1'b1 || busy !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL wr_while_busy: err=%b wz=%b busy=%b done=%b expected 110 1 1 0",
               err_flags, wr_addr_zero, busy, load_done);
    end
    do_strobe(3);
    for (int unsigned a = 0; a < 4; a++) do_read(3, int'(a));
    coef_rst = 1'b1;
    tick();
    coef_rst = 1'b0;
    checks++;
    if (err_flags !== 3'b000 || active_bank !== m_bank) begin
      errors++;
      $display("FAIL coef_rst_clear: err=%b bank=%b expected 000 %b", err_flags, active_bank, m_bank);
    end
  endtask

  task automatic test_bad_taps();
    for (int unsigned i = 0; i < 256; i++) begin
      logic [15:0] v;
      v = 16'(i) ^ 16'hC3A5;
      if (i == 5) begin
        lsb_wr = 1'b1; coef_lsb_data = 8'h77;
        tick();
        lsb_wr = 1'b0;
      end
      wr_tap(0, 0, int'(i), v, 1'b0, i == 255);
      if (i == 0) begin
        checks++;
        if (err_flags !== 3'b001) begin
          errors++;
          $display("FAIL bad_taps: err=%b expected 001", err_flags);
        end
      end
    end
    do_commit(1'b1);
    do_strobe(0);
    do_read(0, 0);
    do_read(0, 5);
    do_read(0, 128);
    do_read(0, 255);
  endtask

  task automatic test_async_reset_and_soft_reset();
    wr_tap(2, 1, 0, 16'hBEEF, 1'b0, 1'b1);
    do_commit(1'b1);
    #3;
    reset_n = 1'b0;
    #1;
    m_bank = '0;
    checks++;
    if (active_bank !== 4'b0000 || busy !== 1'b0 || err_flags !== 3'b000 ||
        rd_data !== 16'h0 || wr_addr_zero !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: bank=%b busy=%b err=%b rd_data=%h wz=%b expected 0000 0 000 0000 1",
               active_bank, busy, err_flags, rd_data, wr_addr_zero);
    end
    #2;
    reset_n = 1'b1;
    tick();
    coef_rst = 1'b1; msb_wr = 1'b1; lsb_wr = 1'b1; coef_msb_data = 8'h99; coef_lsb_data = 8'h99;
    filt_sel = 2'd0; taps_per_filter = 9'd2;
    tick();
    coef_rst = 1'b0; msb_wr = 1'b0; lsb_wr = 1'b0;
    checks++;
    if (wr_addr_zero !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL coef_rst_drop: wz=%b done=%b expected 1 0", wr_addr_zero, load_done);
    end
    wr_tap(0, 2, 0, 16'h0A0B, 1'b0, 1'b0);
    checks++;
    if (wr_addr_zero !== 1'b0) begin
      errors++;
      $display("FAIL ptr_after_drop: wz=%b expected 0", wr_addr_zero);
    end
    wr_tap(0, 2, 1, 16'h0C0D, 1'b1, 1'b1);
    do_commit(1'b1);
    do_strobe(0);
    do_read(0, 0);
    do_read(0, 1);
  endtask

  initial begin
    test_reset();
    test_load_commit();
    test_shadow_isolation();
    test_commit_strobe_same_cycle();
    test_errors();
    test_bad_taps();
    test_async_reset_and_soft_reset();
    tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL rd_outstanding: %0d reads returned no data, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
